// File: rtl/wb_stage_ctrl.sv
// Writeback-stage controller: decodes the retiring instruction, drives the RF write port,
// owns IR4 for forwarding, a RUN/HALTED state machine and saturating perf counters.
module wb_stage_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int INSTR_WIDTH    = 8,
  parameter int REG_ADDR_WIDTH = 2,
  parameter int PERF_WIDTH     = 16,
  parameter int ORI_REG        = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wb_valid,
  input  logic [INSTR_WIDTH-1:0]    wb_instr,
  input  logic [DATA_WIDTH-1:0]     wb_alu_result,
  input  logic [DATA_WIDTH-1:0]     wb_mem_data,
  input  logic                      resume,
  input  logic                      perf_clear,
  output logic                      rf_write,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  output logic [INSTR_WIDTH-1:0]    ir4,
  output logic                      ir4_valid,
  output logic                      halted,
  output logic                      stop_pulse,
  output logic [PERF_WIDTH-1:0]     cycle_count,
  output logic [PERF_WIDTH-1:0]     retired_count
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  localparam logic [REG_ADDR_WIDTH-1:0] ORI_ADDR = REG_ADDR_WIDTH'(ORI_REG);
  localparam logic [PERF_WIDTH-1:0]     PERF_MAX = '1;

  state_t state, state_nxt;

  logic [3:0]                op;
  logic [REG_ADDR_WIDTH-1:0] rx;
  logic                      is_shift, is_ori, is_add, is_sub, is_nand, is_load, is_stop;
  logic                      writes_rf, active, stop_fire, run;
  logic                      instr_unused;

  assign op           = wb_instr[3:0];
  assign rx           = wb_instr[INSTR_WIDTH-1 -: REG_ADDR_WIDTH];
  assign instr_unused = ^wb_instr[INSTR_WIDTH-REG_ADDR_WIDTH-1:4];

  // shift and ori ignore op[3]; everything else is a full 4-bit match
  assign is_shift = (op[2:0] == 3'b011);
  assign is_ori   = (op[2:0] == 3'b111);
  assign is_add   = (op == 4'b0100);
  assign is_sub   = (op == 4'b0110);
  assign is_nand  = (op == 4'b1000);
  assign is_load  = (op == 4'b0000);
  assign is_stop  = (op == 4'b0001);

  assign writes_rf = is_shift | is_ori | is_add | is_sub | is_nand | is_load;
  assign run       = (state == RUN);
  assign active    = run & wb_valid;
  assign stop_fire = active & is_stop;

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (stop_fire) state_nxt = HALTED;
      HALTED:  if (resume)    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    rf_write = active & writes_rf;
    rf_waddr = is_ori  ? ORI_ADDR    : rx;
    rf_wdata = is_load ? wb_mem_data : wb_alu_result;
  end

  assign halted = (state == HALTED);

  always_ff @(posedge clock) begin
    if (reset) stop_pulse <= 1'b0;
    else       stop_pulse <= stop_fire;
  end

  // IR4 freezes on the stop itself so forwarding still sees the last real instruction
  always_ff @(posedge clock) begin
    if (reset) begin
      ir4       <= '0;
      ir4_valid <= 1'b0;
    end else if (run && !stop_fire) begin
      ir4_valid <= wb_valid;
      if (wb_valid) ir4 <= wb_instr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || perf_clear) begin
      cycle_count   <= '0;
      retired_count <= '0;
    end else begin
      if (run && cycle_count != PERF_MAX)      cycle_count   <= cycle_count + PERF_WIDTH'(1);
      if (active && retired_count != PERF_MAX) retired_count <= retired_count + PERF_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// Scoreboard bench for wb_stage_ctrl: driver pushes model predictions, negedge monitor compares.
module tb_wb_stage_ctrl;

  logic       clock = 1'b0;
  logic       reset, wb_valid, resume, perf_clear;
  logic [7:0] wb_instr, wb_alu_result, wb_mem_data;
  logic       rf_write, ir4_valid, halted, stop_pulse;
  logic [1:0] rf_waddr;
  logic [7:0] rf_wdata, ir4;
  logic [15:0] cycle_count, retired_count;

  always #5 clock = ~clock;

  wb_stage_ctrl dut (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_instr(wb_instr),
    .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data), .resume(resume),
    .perf_clear(perf_clear), .rf_write(rf_write), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ir4(ir4), .ir4_valid(ir4_valid), .halted(halted), .stop_pulse(stop_pulse),
    .cycle_count(cycle_count), .retired_count(retired_count)
  );

  typedef struct {
    logic       w;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] ir;
    logic       irv, h, sp;
    logic [15:0] cc, rc;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int checks = 0;
  int errors = 0;

  // reference model state (what the registered outputs should show right now)
  bit       m_h, m_sp, m_irv;
  logic [7:0] m_ir;
  int       m_cc, m_rc;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("rf_write", 32'(rf_write), 32'(me.w));
      chk("rf_waddr", 32'(rf_waddr), 32'(me.a));
      chk("rf_wdata", 32'(rf_wdata), 32'(me.d));
      chk("ir4", 32'(ir4), 32'(me.ir));
      chk("ir4_valid", 32'(ir4_valid), 32'(me.irv));
      chk("halted", 32'(halted), 32'(me.h));
      chk("stop_pulse", 32'(stop_pulse), 32'(me.sp));
      chk("cycle_count", 32'(cycle_count), 32'(me.cc));
      chk("retired_count", 32'(retired_count), 32'(me.rc));
    end
  end

  task automatic model_reset();
    m_h = 0; m_sp = 0; m_irv = 0; m_ir = '0; m_cc = 0; m_rc = 0;
  endtask

  // Drive one cycle, predict this cycle's outputs, then advance the model over the edge.
  task automatic step(input bit v, input logic [7:0] ins, input logic [7:0] alu, input logic [7:0] mem,
                      input bit res, input bit clr, input bit rst);
    exp_t e;
    bit act, sp;
    logic [3:0] op;
    wb_valid = v; wb_instr = ins; wb_alu_result = alu; wb_mem_data = mem;
    resume = res; perf_clear = clr; reset = rst;
    op  = ins[3:0];
    act = !m_h && v;
    e.w  = act && (op inside {4'b0011, 4'b1011, 4'b0111, 4'b1111, 4'b0100, 4'b0110, 4'b1000, 4'b0000});
    e.a  = (op == 4'b0111 || op == 4'b1111) ? 2'd1 : ins[7:6];
    e.d  = (op == 4'b0000) ? mem : alu;
    e.ir = m_ir; e.irv = m_irv; e.h = m_h; e.sp = m_sp;
    e.cc = m_cc[15:0]; e.rc = m_rc[15:0];
    q.push_back(e);
    sp = 0;
    if (rst) model_reset();
    else begin
      if (clr) begin m_cc = 0; m_rc = 0; end
      else if (!m_h) begin
        if (m_cc < 65535) m_cc++;
        if (act && m_rc < 65535) m_rc++;
      end
      if (!m_h) begin
        if (act && op == 4'b0001) begin m_h = 1; sp = 1; end
        else if (v) begin m_ir = ins; m_irv = 1; end
        else m_irv = 0;
      end else if (res) m_h = 0;
      m_sp = sp;
    end
    @(posedge clock); #1;
  endtask

  task automatic inst(input logic [7:0] ins, input logic [7:0] alu, input logic [7:0] mem);
    step(1, ins, alu, mem, 0, 0, 0);
  endtask

  logic [7:0] tbl [8];

  initial begin
    reset = 1; wb_valid = 0; wb_instr = 0; wb_alu_result = 0; wb_mem_data = 0;
    resume = 0; perf_clear = 0;
    @(posedge clock); @(posedge clock); #1;
    model_reset();

    // directed decode cases
    inst({2'd2, 2'b00, 4'b0100}, 8'h3C, 8'h55);   // add Rx=2
    inst({2'd3, 2'b00, 4'b0000}, 8'h11, 8'hA7);   // load Rx=3
    inst({2'd3, 2'b00, 4'b1111}, 8'h22, 8'h33);   // ori -> reg 1
    inst({2'd0, 2'b00, 4'b1011}, 8'h44, 8'h66);   // shift
    tbl[0] = 8'h82; tbl[1] = 8'h4A; tbl[2] = 8'hC5; tbl[3] = 8'h8C;  // store nop bz 1100
    tbl[4] = 8'h46; tbl[5] = 8'h88; tbl[6] = 8'h49; tbl[7] = 8'h1D;  // sub nand bnz bpz
    for (int i = 0; i < 8; i++) inst(tbl[i], 8'(i * 17), 8'hF0);
    step(0, 8'h44, 8'h00, 8'h00, 0, 0, 0);        // bubble

    // stop after 5 RUN cycles, hold halted 10 cycles, resume
    step(0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    for (int i = 0; i < 4; i++) inst(8'h44, 8'(i), 8'h00);
    inst(8'h01, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) inst(8'h84, 8'h5A, 8'h00);
    step(0, 8'h00, 8'h00, 8'h00, 1, 0, 0);
    for (int i = 0; i < 3; i++) inst(8'h44, 8'h77, 8'h00);
    step(0, 8'h00, 8'h00, 8'h00, 1, 0, 0);         // resume in RUN ignored

    // saturation of both counters, then clear beats an active add
    step(0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    for (int i = 0; i < 65540; i++) inst(8'h0A, 8'h00, 8'h00);
    step(1, 8'h44, 8'h12, 8'h00, 0, 1, 0);
    inst(8'h44, 8'h13, 8'h00);

    // reset in the same cycle as an active stop
    inst(8'h84, 8'h01, 8'h00);
    step(1, 8'h01, 8'h00, 8'h00, 1, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 8'h00, 8'h00, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, 8'($urandom), 8'($urandom), 8'($urandom),
           ($urandom % 8) == 0, ($urandom % 32) == 0, ($urandom % 64) == 0);

    @(negedge clock); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
